// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Writeback port bundle: ALU/load requests, issue tracking,
//               busy scoreboard and register-file write port.
// Revision    : 1.0
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              hold;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [31:0]       busy;

  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output hold, issue_valid, issue_rd,
    input  alu_ready, mem_ready, busy,
    input  wb_en, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  hold, issue_valid, issue_rd,
    output alu_ready, mem_ready, busy,
    output wb_en, wb_rd, wb_data
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between ALU and load unit, with a pending-write scoreboard.
// Revision    : 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int DATA_W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_FAV_ALU = 1'b0;
  localparam logic [0:0] ST_FAV_MEM = 1'b1;

  logic [0:0]        r_prio;
  logic [0:0]        w_prio_next;
  logic              w_grant_alu;
  logic              w_grant_mem;
  logic              w_xfer;
  logic [4:0]        w_gnt_rd;
  logic [DATA_W-1:0] w_gnt_data;

  logic              r_wb_en;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [31:1]       r_busy;

  // ---------------------------------------------------------------------------
  // Priority pointer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= ST_FAV_ALU;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  // Next state: point at whichever source lost, hold when nobody was granted
  always_comb begin
    w_prio_next = r_prio;
    if (w_grant_alu) begin
      w_prio_next = ST_FAV_MEM;
    end else if (w_grant_mem) begin
      w_prio_next = ST_FAV_ALU;
    end
  end

  // Output: grants are gated by reset so ready is never seen during reset
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    if (!rst && !bus.hold) begin
      if (bus.alu_valid && bus.mem_valid) begin
        w_grant_alu = (r_prio == ST_FAV_ALU);
        w_grant_mem = (r_prio == ST_FAV_MEM);
      end else begin
        w_grant_alu = bus.alu_valid;
        w_grant_mem = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready = w_grant_alu;
  assign bus.mem_ready = w_grant_mem;

  // ---------------------------------------------------------------------------
  // Granted-source mux
  // ---------------------------------------------------------------------------
  assign w_xfer     = w_grant_alu | w_grant_mem;
  assign w_gnt_rd   = w_grant_mem ? bus.mem_rd   : bus.alu_rd;
  assign w_gnt_data = w_grant_mem ? bus.mem_data : bus.alu_data;

  // ---------------------------------------------------------------------------
  // Writeback register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_xfer && (w_gnt_rd != 5'd0);
      if (w_xfer) begin
        r_wb_rd   <= w_gnt_rd;
        r_wb_data <= w_gnt_data;
      end
    end
  end

  assign bus.wb_en   = r_wb_en;
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;

  // ---------------------------------------------------------------------------
  // Busy scoreboard; x0 is never tracked. A same-cycle issue beats the clear.
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 1; i < 32; i++) begin : g_busy
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy[i] <= 1'b0;
        end else if (bus.issue_valid && (bus.issue_rd == 5'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_xfer && (w_gnt_rd == 5'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.busy = {r_busy, 1'b0};

  ready_onehot_a : assert property (@(posedge clk) disable iff (rst)
                                    !(w_grant_alu && w_grant_mem));

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Scoreboard bench: directed scenarios plus random traffic,
//               checked against a cycle-level behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DW = 32;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.DATA_W(DW)) bus ();

  wb_port_arbiter #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          ar;
    logic          mr;
    logic          en;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic [31:0]   busy;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  bit            m_fav_mem;
  logic [31:0]   m_busy;
  logic          m_wb_en;
  logic [4:0]    m_wb_rd;
  logic [DW-1:0] m_wb_data;
  int            m_last_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("alu_ready", 64'(bus.alu_ready), 64'(e.ar));
      chk("mem_ready", 64'(bus.mem_ready), 64'(e.mr));
      chk("wb_en",     64'(bus.wb_en),     64'(e.en));
      chk("wb_rd",     64'(bus.wb_rd),     64'(e.rd));
      chk("wb_data",   64'(bus.wb_data),   64'(e.data));
      chk("busy",      64'(bus.busy),      64'(e.busy));
    end
  end

  // rmode: 0 = reset low, 1 = assert reset mid-cycle, 2 = reset held high
  task automatic step(input bit av, input logic [4:0] ard, input logic [DW-1:0] adat,
                      input bit mv, input logic [4:0] mrd, input logic [DW-1:0] mdat,
                      input bit hd, input bit iv, input logic [4:0] ird, input int rmode);
    exp_t          e;
    int            g;
    logic [4:0]    grd;
    logic [DW-1:0] gdat;
    logic [31:0]   nb;
    @(posedge clk);
    #1;
    bus.alu_valid = av;   bus.alu_rd = ard;   bus.alu_data = adat;
    bus.mem_valid = mv;   bus.mem_rd = mrd;   bus.mem_data = mdat;
    bus.hold = hd;        bus.issue_valid = iv; bus.issue_rd = ird;
    if (rmode == 2) rst = 1'b1;
    else if (rmode == 0) rst = 1'b0;
    if (rmode == 1) begin
      #1;
      rst = 1'b1;
    end
    if (rst) begin
      e = '{ar: 1'b0, mr: 1'b0, en: 1'b0, rd: 5'd0, data: '0, busy: 32'd0};
      m_fav_mem = 1'b0; m_busy = '0; m_wb_en = 1'b0; m_wb_rd = '0; m_wb_data = '0;
      m_last_g = 0;
    end else begin
      if (hd)             g = 0;
      else if (av && mv)  g = m_fav_mem ? 2 : 1;
      else if (av)        g = 1;
      else if (mv)        g = 2;
      else                g = 0;
      e.ar = (g == 1); e.mr = (g == 2);
      e.en = m_wb_en;  e.rd = m_wb_rd;  e.data = m_wb_data;  e.busy = m_busy;
      grd  = (g == 1) ? ard  : mrd;
      gdat = (g == 1) ? adat : mdat;
      nb = m_busy;
      if (g != 0) nb[grd] = 1'b0;
      if (iv)     nb[ird] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (g != 0) begin
        m_wb_en = (grd != 5'd0); m_wb_rd = grd; m_wb_data = gdat;
        m_fav_mem = (g == 1);
      end else begin
        m_wb_en = 1'b0;
      end
      m_last_g = g;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  bit            a_pend, m_pend, r_hold, r_iv;
  logic [4:0]    a_rd, m_rd, r_ird;
  logic [DW-1:0] a_dat, m_dat;

  initial begin
    rst = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = '0;
    bus.hold = 0; bus.issue_valid = 0; bus.issue_rd = 0;
    m_fav_mem = 0; m_busy = '0; m_wb_en = 0; m_wb_rd = '0; m_wb_data = '0; m_last_g = 0;

    // Reset state, with requests present to confirm ready stays low
    step(1, 5, 32'h11, 1, 6, 32'h22, 0, 1, 3, 2);
    step(0, 0, '0, 0, 0, '0, 0, 0, 0, 2);

    // Round-robin after reset
    for (int k = 0; k < 4; k++) step(1, 5, 32'h100 + k, 1, 6, 32'h200 + k, 0, 0, 0, 0);
    idle(2);

    // Lone requester
    for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 9, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2);

    // Write to x0
    step(1, 0, 32'h1234, 0, 0, '0, 0, 0, 0, 0);
    idle(2);

    // Scoreboard set / clear / same-cycle set wins
    step(0, 0, '0, 0, 0, '0, 0, 1, 7, 0);
    idle(2);
    step(1, 7, 32'h77, 0, 0, '0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, '0, 0, 0, '0, 0, 1, 7, 0);
    step(1, 7, 32'h78, 0, 0, '0, 0, 1, 7, 0);
    idle(2);
    step(0, 0, '0, 1, 7, 32'h79, 0, 0, 0, 0);
    idle(1);

    // Hold from reset state: fresh reset, then hold two cycles and release
    step(0, 0, '0, 0, 0, '0, 0, 0, 0, 2);
    step(1, 12, 32'hA1, 1, 13, 32'hB1, 1, 0, 0, 0);
    step(1, 12, 32'hA1, 1, 13, 32'hB1, 1, 0, 0, 0);
    step(1, 12, 32'hA1, 1, 13, 32'hB1, 0, 0, 0, 0);
    step(0, 0, '0, 1, 13, 32'hB1, 0, 0, 0, 0);
    idle(1);

    // Reset mid-operation with wb_en=1 and busy=0x80
    step(1, 3, 32'hCAFE, 0, 0, '0, 0, 1, 7, 0);
    step(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, '0, 0, 0, 0, 2);
    step(1, 4, 32'h44, 1, 8, 32'h88, 0, 0, 0, 0);
    step(0, 0, '0, 1, 8, 32'h88, 0, 0, 0, 0);
    idle(1);

    // Random traffic honouring the hold-stable rule
    a_pend = 0; m_pend = 0;
    a_rd = 0; m_rd = 0; a_dat = '0; m_dat = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!a_pend && ($urandom_range(0, 9) < 6)) begin
        a_pend = 1; a_rd = 5'($urandom_range(0, 31)); a_dat = $urandom;
      end
      if (!m_pend && ($urandom_range(0, 9) < 5)) begin
        m_pend = 1; m_rd = 5'($urandom_range(0, 31)); m_dat = $urandom;
      end
      r_hold = ($urandom_range(0, 9) < 2);
      r_iv   = ($urandom_range(0, 9) < 4);
      r_ird  = 5'($urandom_range(0, 31));
      step(a_pend, a_rd, a_dat, m_pend, m_rd, m_dat, r_hold, r_iv, r_ird, 0);
      if (m_last_g == 1) a_pend = 0;
      if (m_last_g == 2) m_pend = 0;
    end
    idle(2);

    for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the two writeback sources, the ALU and the load unit, using round-robin arbitration with valid/ready handshakes. It also keeps a 32-bit busy scoreboard so decode can stall on pending destination registers. It sits between the execute/memory stages and the register file's `rd`/`write_enable`/`write_data` inputs, and drives them from registered outputs.

## Interface
- `DATA_W`, default 32: width of the writeback data.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `alu_valid`  in  1: the ALU has a result to write.
- `alu_rd`  in  5: ALU destination register.
- `alu_data`  in  DATA_W: ALU result.
- `alu_ready`  out  1: the ALU request is granted this cycle (combinational).
- `mem_valid`  in  1: the load unit has a result to write.
- `mem_rd`  in  5: load destination register.
- `mem_data`  in  DATA_W: load result.
- `mem_ready`  out  1: the load request is granted this cycle (combinational).
- `hold`  in  1: freezes the write port; no grant is given while it is high.
- `issue_valid`  in  1: decode issued an instruction that will write `issue_rd`.
- `issue_rd`  in  5: destination register of the issued instruction.
- `busy`  out  32: scoreboard; bit n high means a write to xn is pending.
- `wb_en`  out  1: write enable to the register file.
- `wb_rd`  out  5: write address to the register file.
- `wb_data`  out  DATA_W: write data to the register file.

## Operation
- **Priority pointer.** `prio` is 1 bit: 0 means the ALU is favoured, 1 means MEM is favoured. Reset value is 0.
- **Grant rules.** Evaluated only when `hold`=0.
  - Both valid: grant the favoured source.
  - Only one valid: grant that source.
  - None valid: no grant.
  - `hold`=1: `alu_ready`=`mem_ready`=0 regardless of the valid inputs.
- **Pointer update.** After any grant, `prio` points at the source that was not granted. With no grant, `prio` holds. A lone requester can therefore be granted on consecutive cycles.
- **Ready signals.** `alu_ready` and `mem_ready` are one-hot or zero, never both high. Each is a pure function of `alu_valid`, `mem_valid`, `hold` and `prio`.
- **Transfer.** A transfer occurs on the edge where valid and ready are both high. The requester must hold `rd` and `data` stable while valid is high and ready is low.
- **Writeback register.** On a transfer edge:
  - `wb_rd` and `wb_data` load the granted source's fields.
  - `wb_en` is set to 1 only if the granted `rd` is not 0.
- A transfer with `rd`=0 is accepted and consumed, but it produces `wb_en`=0.
- With no transfer, `wb_en` is 0 on the next cycle. `wb_rd` and `wb_data` hold their last values.
- **Scoreboard updates on each edge:**
  - Set `busy[issue_rd]` if `issue_valid` is high.
  - Clear `busy[rd]` of the granted transfer, if any.
  - If the set and the clear target the same register in the same cycle, the set wins (a new producer is in flight).
- `busy[0]` is constant 0; issues and writes to x0 have no scoreboard effect.
- **Reset.** Asserting `rst` at any time, including mid-transfer, forces:
  - `busy`=0, `prio`=0
  - `wb_en`=0, `wb_rd`=0, `wb_data`=0
- Any in-flight grant is dropped. Requesters re-present after reset.

## Timing
- **Reset values:** `wb_en`=0, `wb_rd`=0, `wb_data`=0, `busy`=0. `alu_ready` and `mem_ready` are 0 while `rst` is high.
- **Grant latency:** 0 cycles. Ready is asserted in the same cycle as valid, if won.
- **Transfer to write port:** 1 cycle. `wb_*` are valid in the cycle after the transfer edge.
- **Register commit:** the register file commits on the following edge, 2 edges after the transfer.
- **Scoreboard clear:** visible on `busy` in the cycle after the transfer edge, together with `wb_en`. Decode must also account for the register file's 1-cycle registered read.
- **Scoreboard set:** visible on `busy` in the cycle after the `issue_valid` edge.
- **Throughput:** one write per cycle maximum. With both sources continuously valid, grants alternate ALU, MEM, ALU, ...
- **`hold` behaviour:** takes effect in the same cycle. `wb_en` is 0 in the cycle after any held cycle.

## Test plan
- **Round-robin after reset:** reset, then `alu_valid`=`mem_valid`=1 for 4 cycles with `alu_rd`=5 and `mem_rd`=6.
  - Grants go ALU, MEM, ALU, MEM.
  - `wb_rd` reads 5, 6, 5, 6 one cycle later, with `wb_en`=1 throughout.
- **Lone requester:** `mem_valid`=1 alone for 3 cycles with `mem_rd`=9 and `mem_data`=0xDEADBEEF.
  - `mem_ready`=1 on all 3 cycles.
  - `wb_data`=0xDEADBEEF and `wb_en`=1 on the following 3 cycles.
- **Write to x0:** ALU transfer with `alu_rd`=0 and data 0x1234.
  - `alu_ready`=1, next-cycle `wb_en`=0, `busy`=0.
- **Scoreboard:** issue `rd`=7, then 3 cycles later an ALU transfer to `rd`=7.
  - `busy[7]` rises 1 cycle after the issue and falls 1 cycle after the transfer.
  - Issuing `rd`=7 in the same cycle as a transfer to `rd`=7 leaves `busy[7]`=1.
- **Hold:** both requesters valid and `hold`=1 for 2 cycles.
  - Both ready signals stay 0, `wb_en`=0, `prio` is unchanged.
  - On release, the ALU is granted first (from reset state).
- **Reset mid-operation:** assert `rst` asynchronously while `wb_en`=1 and `busy`=0x0000_0080.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, `prio`=0 and the first dual request grants the ALU.
